writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the pending-write queue depth (power of two, >=2).
REQ-002 Clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 Reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Issue_en  in  1  decode issues an instruction that will write Issue_addr.
REQ-005 Issue_addr  in  5  destination register of the issued instruction.
REQ-006 Alu_valid / Alu_addr[4:0] / Alu_data[31:0]  in  ALU result offer.
REQ-007 Alu_ready  out  1  ALU result accepted this cycle when Alu_valid=1.
REQ-008 Mem_valid / Mem_addr[4:0] / Mem_data[31:0]  in  load result offer.
REQ-009 Mem_ready  out  1  load result accepted this cycle when Mem_valid=1.
REQ-010 Write_En / Write_addr[4:0] / Write_data[31:0]  out  registered write port to the register file.
REQ-011 Busy_mask  out  32  bit i=1: register i has a write outstanding.
REQ-012 Issue_conflict  out  1  registered one-cycle pulse: Issue_en hit a busy register.
REQ-013 Count  out  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-014 Readiness SHALL depend only on Count at cycle start and Mem_valid: Mem_ready = Count<DEPTH; Alu_ready = Count<DEPTH-1, or Count<DEPTH with Mem_valid=0.
REQ-015 When both results are accepted in one cycle, the Mem entry SHALL be enqueued ahead of the ALU entry.
REQ-016 An accepted result with address 0 SHALL be consumed (handshake completes) but not enqueued.
REQ-017 Each cycle with Count>0 SHALL dequeue exactly one entry (FIFO order); Write_En SHALL be 1 in the following cycle with that entry's addr/data, else 0.
REQ-018 Minimum latency: valid&ready in cycle N -> Write_En=1 in cycle N+2; no bypass path.
REQ-019 Enqueue and dequeue in the same cycle SHALL both occur; Count SHALL change by (enqueued - 1).
REQ-020 A slot freed by a dequeue SHALL NOT be offered as ready in the same cycle.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; Count SHALL never exceed DEPTH nor underflow.
REQ-022 Issue_en with Issue_addr!=0 SHALL set Busy_mask[Issue_addr] at the next edge; Issue_addr=0 SHALL be ignored.
REQ-023 Busy_mask[Write_addr] SHALL clear at the edge ending a cycle with Write_En=1 (the edge the register file captures).
REQ-024 Set and clear of the same bit at the same edge: set SHALL win.
REQ-025 Issue_en to an already-set busy bit SHALL leave the bit set and pulse Issue_conflict the next cycle.
REQ-026 Busy_mask[0] SHALL always be 0.

Reset
REQ-027 Reset_n=0 SHALL immediately clear: queue pointers, Count=0, Write_En=0, Write_addr=0, Write_data=0, Busy_mask=0, Issue_conflict=0.
REQ-028 During reset Alu_ready and Mem_ready SHALL read 1 (Count=0) but no entry SHALL be stored.
REQ-029 Reset mid-operation SHALL discard all queued entries; no Write_En pulse SHALL follow reset deassertion until a new result is accepted.
REQ-030 Queue storage array need not be reset.

Structure
REQ-031 Shared package wb_pkg SHALL hold DATA_W=32, ADDR_W=5, NUM_REGS=32 and the queue entry type {addr, data}.
REQ-032 The queue SHALL be one sub-module, wb_fifo (2-write-port, 1-read-port, DEPTH entries); arbitration, busy tracking and the output register stay in writeback_unit.

Verification
REQ-033 Alu_valid, addr=5, data=0x1234 in cycle 1 from empty -> Write_En=1, Write_addr=5, Write_data=0x1234 in cycle 3 only.
REQ-034 Mem (addr 3, 0xAAAA) and ALU (addr 4, 0xBBBB) valid together, Count=0 -> both accepted; writes to 3 then 4 in consecutive cycles.
REQ-035 Count=3, DEPTH=4, both valid -> Mem_ready=1, Alu_ready=0; ALU accepted one cycle later; Count never exceeds 4.
REQ-036 Issue_en addr 7, result addr 7 later -> Busy_mask[7] set after issue, cleared at edge ending the Write_En cycle; re-issue of 7 at that edge keeps bit 7 set.
REQ-037 ALU result to addr 0 -> Alu_ready=1, no Write_En, Count unchanged; Issue_en addr 0 -> Busy_mask unchanged.
REQ-038 Reset_n low with Count=3 -> outputs clear asynchronously; after release no Write_En until new input.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback unit: datapath widths and the
// pending-write queue entry {addr, data}.
package wb_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Writeback unit bus: issue port, ALU and load result offers, register-file
// write port and status outputs.
//   master : upstream/environment side (drives issue and result offers)
//   slave  : writeback unit side (drives readies, write port, status)
interface writeback_unit_if
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) ();

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                issue_en;
  logic [ADDR_W-1:0]   issue_addr;

  logic                alu_valid;
  logic [ADDR_W-1:0]   alu_addr;
  logic [DATA_W-1:0]   alu_data;
  logic                alu_ready;

  logic                mem_valid;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_data;
  logic                mem_ready;

  logic                write_en;
  logic [ADDR_W-1:0]   write_addr;
  logic [DATA_W-1:0]   write_data;

  logic [NUM_REGS-1:0] busy_mask;
  logic                issue_conflict;
  logic [CW-1:0]       count;

  modport master (
    output issue_en, issue_addr,
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready,
    input  write_en, write_addr, write_data,
    input  busy_mask, issue_conflict, count
  );

  modport slave (
    input  issue_en, issue_addr,
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready,
    output write_en, write_addr, write_data,
    output busy_mask, issue_conflict, count
  );

endinterface

// File: rtl/wb_fifo.sv
// Pending-write queue: DEPTH entries, two write ports, one read port.
// Port a is always enqueued ahead of port b when both push together.
// Ports: clk, rst_n, push_a/entry_a, push_b/entry_b, pop, head (current
// oldest entry), count (occupancy). The caller guarantees no overflow and
// only pops when count > 0.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_a,
  input  wb_entry_t              entry_a,
  input  logic                   push_b,
  input  wb_entry_t              entry_b,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, wr_ptr_b;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_b = push_a ? wr_ptr_q + PW'(1) : wr_ptr_q;
    wr_ptr_d = wr_ptr_q + PW'(push_a) + PW'(push_b);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_a) mem_q[wr_ptr_q] <= entry_a;
    if (push_b) mem_q[wr_ptr_b] <= entry_b;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: arbitrates ALU and load results into a pending-write
// queue, drains one entry per cycle to a registered register-file write
// port, and tracks registers with outstanding writes.
// Ports: clk, rst_n (async, active-low), bus (writeback_unit_if.slave).
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  writeback_unit_if.slave  bus
);

  localparam int unsigned      CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    Full       = CW'(DEPTH);
  localparam logic [CW-1:0]    AlmostFull = CW'(DEPTH - 1);

  logic [CW-1:0]       count;
  logic                mem_push, alu_push, pop;
  wb_entry_t           mem_entry, alu_entry, head;

  logic                wen_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                conflict_q, conflict_d;
  logic                issue_hit;

  // Readiness looks only at occupancy at cycle start, so a slot freed by
  // this cycle's dequeue is never offered. Mem takes priority for the last slot.
  assign bus.mem_ready = count < Full;
  assign bus.alu_ready = (count < AlmostFull) || ((count < Full) && !bus.mem_valid);

  // Results to r0 complete the handshake but are dropped.
  assign mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_addr != '0);
  assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_addr != '0);
  assign pop      = count != '0;

  assign mem_entry = '{addr: bus.mem_addr, data: bus.mem_data};
  assign alu_entry = '{addr: bus.alu_addr, data: bus.alu_data};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_a  (mem_push),
    .entry_a (mem_entry),
    .push_b  (alu_push),
    .entry_b (alu_entry),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );

  assign issue_hit = bus.issue_en && (bus.issue_addr != '0);

  // Clear on the edge the register file captures; a same-edge issue wins.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) busy_d[waddr_q] = 1'b0;
    if (issue_hit) busy_d[bus.issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
    conflict_d = issue_hit && busy_q[bus.issue_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      wen_q      <= pop;
      if (pop) begin
        waddr_q <= head.addr;
        wdata_q <= head.data;
      end
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.write_en       = wen_q;
  assign bus.write_addr     = waddr_q;
  assign bus.write_data     = wdata_q;
  assign bus.busy_mask      = busy_q;
  assign bus.issue_conflict = conflict_q;
  assign bus.count          = count;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios followed by random traffic,
// all checked each cycle against a queue-based reference model.
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_unit_if #(.DEPTH(DEPTH)) bus ();

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  wb_entry_t   exp_q [$];
  logic        exp_wen;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic [31:0] exp_busy;
  logic        exp_conf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_wen   = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    exp_busy  = '0;
    exp_conf  = 1'b0;
  endtask

  task automatic set_in(input logic ie, input logic [4:0] ia,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bus.issue_en   = ie;
    bus.issue_addr = ia;
    bus.alu_valid  = av;
    bus.alu_addr   = aa;
    bus.alu_data   = ad;
    bus.mem_valid  = mv;
    bus.mem_addr   = ma;
    bus.mem_data   = md;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Check outputs mid-cycle, advance the model across the coming edge.
  task automatic cycle();
    int          sz;
    logic        mrdy, ardy;
    wb_entry_t   e;
    logic [31:0] nb;
    logic        nc;
    @(negedge clk);
    sz   = exp_q.size();
    mrdy = sz < DEPTH;
    ardy = (sz < DEPTH - 1) || ((sz < DEPTH) && !bus.mem_valid);
    check("write_en", bus.write_en, exp_wen);
    if (exp_wen) begin
      check("write_addr", bus.write_addr, exp_waddr);
      check("write_data", bus.write_data, exp_wdata);
    end
    check("busy_mask", bus.busy_mask, exp_busy);
    check("issue_conflict", bus.issue_conflict, exp_conf);
    check("count", bus.count, sz);
    check("count_bound", bus.count <= DEPTH, 1);
    check("mem_ready", bus.mem_ready, mrdy);
    check("alu_ready", bus.alu_ready, ardy);
    if (rst_n) begin
      nb = exp_busy;
      nc = 1'b0;
      if (exp_wen) nb[exp_waddr] = 1'b0;
      if (bus.issue_en && bus.issue_addr != 0) begin
        nc = exp_busy[bus.issue_addr];
        nb[bus.issue_addr] = 1'b1;
      end
      nb[0] = 1'b0;
      if (sz > 0) begin
        e         = exp_q.pop_front();
        exp_wen   = 1'b1;
        exp_waddr = e.addr;
        exp_wdata = e.data;
      end else begin
        exp_wen = 1'b0;
      end
      if (bus.mem_valid && mrdy && bus.mem_addr != 0) begin
        e.addr = bus.mem_addr;
        e.data = bus.mem_data;
        exp_q.push_back(e);
      end
      if (bus.alu_valid && ardy && bus.alu_addr != 0) begin
        e.addr = bus.alu_addr;
        e.data = bus.alu_data;
        exp_q.push_back(e);
      end
      exp_busy = nb;
      exp_conf = nc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_reset();
    idle();
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    // Single ALU result: write appears two cycles later, once.
    set_in(1'b0, 5'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    cycle();
    idle();
    cycles(4);

    // Mem and ALU together: mem written first.
    set_in(1'b0, 5'd0, 1'b1, 5'd4, 32'hBBBB, 1'b1, 5'd3, 32'hAAAA);
    cycle();
    idle();
    cycles(4);

    // Sustained dual offers drive occupancy to the full boundary.
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 5'd0, 1'b1, 5'(i + 8), 32'(i * 17 + 1), 1'b1, 5'(i + 16), 32'(i * 31 + 2));
      cycle();
    end
    idle();
    cycles(6);

    // Busy tracking with re-issue on the clearing edge.
    set_in(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle();
    set_in(1'b0, 5'd0, 1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'd0);
    cycle();
    idle();
    cycle();
    set_in(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle();
    idle();
    cycles(3);

    // Address 0: consumed, never written, never busy.
    set_in(1'b1, 5'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    cycle();
    idle();
    cycles(3);

    // Asynchronous reset with entries queued.
    set_in(1'b1, 5'd9, 1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11);
    cycles(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_write_en", bus.write_en, 1'b0);
    check("rst_write_addr", bus.write_addr, 5'd0);
    check("rst_write_data", bus.write_data, 32'd0);
    check("rst_busy", bus.busy_mask, 32'd0);
    check("rst_conflict", bus.issue_conflict, 1'b0);
    check("rst_count", bus.count, 0);
    check("rst_mem_ready", bus.mem_ready, 1'b1);
    check("rst_alu_ready", bus.alu_ready, 1'b1);
    model_reset();
    cycles(2);
    idle();
    rst_n = 1'b1;
    cycles(4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 3) == 0, 5'($urandom),
             $urandom_range(0, 9) < 6, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             $urandom,
             $urandom_range(0, 9) < 5, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             $urandom);
      cycle();
    end
    idle();
    cycles(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
